// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg
//   Shared definitions for the simulation-control peripheral:
//   register addresses, the exit codes the controller generates itself,
//   and the run-control state encoding.
package sim_ctrl_pkg;

    localparam logic [2:0] REG_EXIT   = 3'd0;
    localparam logic [2:0] REG_CON    = 3'd1;
    localparam logic [2:0] REG_WDOG   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_CYC0   = 3'd4;
    localparam logic [2:0] REG_CYC1   = 3'd5;
    localparam logic [2:0] REG_CYC2   = 3'd6;
    localparam logic [2:0] REG_CYC3   = 3'd7;

    localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;
    localparam logic [7:0] EXIT_WDOG    = 8'hFE;

    typedef enum logic {
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   visible on pop_data while empty=0. A push into a full FIFO is dropped
//   and latches the sticky overflow flag, unless a pop happens in the same
//   cycle, in which case both succeed and the level is unchanged.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   push, push_data   write request and data
//   pop               read request (ignored when empty)
//   pop_data          head entry
//   full, empty       occupancy flags
//   level             number of stored entries (0..DEPTH)
//   overflow          sticky: a push was dropped since reset
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // A pop frees the slot being written this cycle, so a full FIFO can
    // still accept a push when it is popped at the same time.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl
//   Memory-mapped simulation-control peripheral. Firmware ends the run by
//   writing EXIT; otherwise a watchdog (armed by the first WDOG write) or a
//   global cycle budget ends it with EXIT_WDOG / EXIT_TIMEOUT. Once finished
//   the controller stays in DONE until reset and the cycle counter freezes.
//   Characters written to CON stream out through a console FIFO.
//
//   Optional build macro: SIM_CTRL_CONSOLE_EN enables the console FIFO.
//   Without it, CON writes are ignored, con_valid/con_data stay 0 and
//   STATUS reports an empty FIFO. The con_* ports exist in both builds.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   cs, we       register select and write strobe
//   addr, wdata  register address and write data
//   rdata        registered read data, valid the cycle after a read
//   finish       run has ended (sticky until reset)
//   exit_code    reason/code, valid while finish=1
//   con_valid    console byte available
//   con_data     console byte
//   con_ready    consumer accepts byte when con_valid & con_ready
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES  = 100000,
    parameter int WDOG_CYCLES = 4096,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       finish,
    output logic [7:0] exit_code,
    output logic       con_valid,
    output logic [7:0] con_data,
    input  logic       con_ready
);

    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W = $clog2(WDOG_CYCLES + 2);

    state_t            state;
    state_t            state_next;
    logic [7:0]        exit_q;
    logic [7:0]        exit_next;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       cnt_ext;
    logic [31:0]       snap;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_armed;
    logic              exit_wr;
    logic              wdog_wr;
    logic              con_wr;
    logic              wdog_expire;
    logic              budget_hit;
    logic [7:0]        rd_val;
    logic [3:0]        lvl4;
    logic [7:0]        status;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;
    logic [LW-1:0]     fifo_level;

    assign exit_wr = cs && we && (addr == REG_EXIT);
    assign wdog_wr = cs && we && (addr == REG_WDOG) && (state == ST_RUN);
    assign con_wr  = cs && we && (addr == REG_CON);

    // Expiry is flagged while the count is 1 so finish rises exactly
    // WDOG_CYCLES edges after the last kick; a kick in that cycle wins.
    assign wdog_expire = wd_armed && (wd_cnt == WD_W'(1)) && !wdog_wr && (state == ST_RUN);
    assign budget_hit  = (MAX_CYCLES != 0) && (cnt == CNT_W'(MAX_CYCLES - 1));

    assign finish    = (state == ST_DONE);
    assign exit_code = exit_q;
    assign cnt_ext   = 32'(cnt);

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            exit_q <= 8'h00;
        end else begin
            state  <= state_next;
            exit_q <= exit_next;
        end
    end

    // Leave RUN on the highest-priority event: EXIT write, then watchdog,
    // then budget. DONE absorbs everything until reset.
    always_comb begin
        state_next = state;
        exit_next  = exit_q;
        case (state)
            ST_RUN: begin
                if (exit_wr) begin
                    state_next = ST_DONE;
                    exit_next  = wdata;
                end else if (wdog_expire) begin
                    state_next = ST_DONE;
                    exit_next  = EXIT_WDOG;
                end else if (budget_hit) begin
                    state_next = ST_DONE;
                    exit_next  = EXIT_TIMEOUT;
                end
            end
            default: begin
                state_next = ST_DONE;
            end
        endcase
    end

    // The counter only advances while the run continues past this edge, so
    // the value read after finish is the last cycle spent in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state_next == ST_RUN) && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Watchdog down-counter; a zero period leaves it permanently disarmed.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_armed <= 1'b0;
            wd_cnt   <= '0;
        end else if (wdog_wr && (WDOG_CYCLES != 0)) begin
            wd_armed <= 1'b1;
            wd_cnt   <= WD_W'(WDOG_CYCLES);
        end else if (wd_armed && (state == ST_RUN) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - WD_W'(1);
        end
    end

`ifdef SIM_CTRL_CONSOLE_EN
    logic [7:0] fifo_head;
    logic       fifo_pop;

    assign fifo_pop  = con_valid && con_ready;
    assign con_valid = !fifo_empty;
    assign con_data  = con_valid ? fifo_head : 8'h00;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (con_wr),
        .push_data (wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .overflow  (fifo_ovf)
    );
`else
    logic unused_console;

    assign unused_console = con_ready ^ con_wr;
    assign con_valid      = 1'b0;
    assign con_data       = 8'h00;
    assign fifo_full      = 1'b0;
    assign fifo_empty     = 1'b1;
    assign fifo_ovf       = 1'b0;
    assign fifo_level     = '0;
`endif

    assign lvl4   = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);
    assign status = {finish, fifo_full, fifo_empty, fifo_ovf, lvl4};

    // Read mux. CYC byte 0 returns the live counter (which is what gets
    // snapshotted); the upper bytes come from the snapshot.
    always_comb begin
        rd_val = 8'h00;
        case (addr)
            REG_STATUS: rd_val = status;
            REG_CYC0:   rd_val = cnt_ext[7:0];
            REG_CYC1:   rd_val = snap[15:8];
            REG_CYC2:   rd_val = snap[23:16];
            REG_CYC3:   rd_val = snap[31:24];
            default:    rd_val = 8'h00;
        endcase
    end

    // Registered read data and counter snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 8'h00;
            snap  <= '0;
        end else if (cs && !we) begin
            rdata <= rd_val;
            if (addr == REG_CYC0) begin
                snap <= cnt_ext;
            end
        end
    end

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl
//   Directed bench for sim_ctrl with MAX_CYCLES=100, WDOG_CYCLES=8,
//   FIFO_DEPTH=4. Console checks follow the SIM_CTRL_CONSOLE_EN build.
module tb_sim_ctrl;
    import sim_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       finish;
    logic [7:0] exit_code;
    logic       con_valid;
    logic [7:0] con_data;
    logic       con_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sim_ctrl #(
        .MAX_CYCLES  (100),
        .WDOG_CYCLES (8),
        .CNT_W       (32),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .finish    (finish),
        .exit_code (exit_code),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready)
    );

    // Advance one clock; everything is driven and sampled 1 ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [2:0] a,
                                 input logic [7:0] d);
        cs    = c;
        we    = w;
        addr  = a;
        wdata = d;
        step();
        cs    = 1'b0;
        we    = 1'b0;
        addr  = 3'd0;
        wdata = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        end
    endtask

    task automatic readReg(input logic [2:0] a, output logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, 8'h00);
        d = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reset is released just after an edge, so the next edge is cycle 1.
    task automatic doReset();
        reset     = 1'b1;
        cs        = 1'b0;
        we        = 1'b0;
        addr      = 3'd0;
        wdata     = 8'h00;
        con_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] d;

        // Reset values
        doReset();
        checkOutput("reset_rdata", rdata, 8'h00);
        checkOutput("reset_finish", finish, 1'b0);
        checkOutput("reset_exit", exit_code, 8'h00);
        checkOutput("reset_con_valid", con_valid, 1'b0);
        checkOutput("reset_con_data", con_data, 8'h00);

        // Budget: finish exactly 100 edges after reset release
        idle(99);
        checkOutput("budget_not_yet", finish, 1'b0);
        idle(1);
        checkOutput("budget_finish", finish, 1'b1);
        checkOutput("budget_code", exit_code, 8'hFF);
        readReg(REG_CYC0, d);
        checkOutput("budget_cyc0", d, 8'h63);
        readReg(REG_CYC1, d);
        checkOutput("budget_cyc1", d, 8'h00);
        readReg(REG_CYC2, d);
        checkOutput("budget_cyc2", d, 8'h00);
        readReg(REG_CYC3, d);
        checkOutput("budget_cyc3", d, 8'h00);
        readReg(REG_STATUS, d);
        checkOutput("budget_status", d, 8'hA0);

        // EXIT write at cycle 10; counter freezes, later EXIT ignored
        doReset();
        idle(9);
        applyStimulus(1'b1, 1'b1, REG_EXIT, 8'h00);
        checkOutput("exit_finish", finish, 1'b1);
        checkOutput("exit_code0", exit_code, 8'h00);
        readReg(REG_CYC0, d);
        checkOutput("exit_cyc_frozen", d, 8'h09);
        idle(5);
        applyStimulus(1'b1, 1'b1, REG_EXIT, 8'h55);
        checkOutput("exit_second_ignored", exit_code, 8'h00);
        readReg(REG_CYC0, d);
        checkOutput("exit_cyc_still", d, 8'h09);

        // Watchdog: kick at cycle 5, expiry at cycle 13
        doReset();
        idle(4);
        applyStimulus(1'b1, 1'b1, REG_WDOG, 8'h00);
        idle(7);
        checkOutput("wdog_not_yet", finish, 1'b0);
        idle(1);
        checkOutput("wdog_finish", finish, 1'b1);
        checkOutput("wdog_code", exit_code, 8'hFE);

        // Watchdog kicked every 7 cycles never expires; a kick on the
        // expiry cycle itself reloads it
        doReset();
        applyStimulus(1'b1, 1'b1, REG_WDOG, 8'h00);
        for (int k = 0; k < 8; k++) begin
            idle(6);
            applyStimulus(1'b1, 1'b1, REG_WDOG, 8'h00);
        end
        checkOutput("wdog_kicked_alive", finish, 1'b0);
        idle(7);
        applyStimulus(1'b1, 1'b1, REG_WDOG, 8'h00);
        idle(7);
        checkOutput("wdog_late_kick_alive", finish, 1'b0);
        idle(1);
        checkOutput("wdog_late_kick_expire", finish, 1'b1);
        checkOutput("wdog_late_kick_code", exit_code, 8'hFE);

`ifdef SIM_CTRL_CONSOLE_EN
        // Console: "Hi\n" held, then drained in order
        doReset();
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h48);
        checkOutput("con_valid_after_push", con_valid, 1'b1);
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h69);
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h0A);
        readReg(REG_STATUS, d);
        checkOutput("con_status_level3", d, 8'h03);
        checkOutput("con_head_H", con_data, 8'h48);
        con_ready = 1'b1;
        idle(1);
        checkOutput("con_head_i", con_data, 8'h69);
        idle(1);
        checkOutput("con_head_nl", con_data, 8'h0A);
        idle(1);
        checkOutput("con_drained", con_valid, 1'b0);
        con_ready = 1'b0;

        // Overflow on a depth-4 FIFO, then push+pop while full
        doReset();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b1, REG_CON, 8'(k));
        end
        readReg(REG_STATUS, d);
        checkOutput("ovf_status", d, 8'h54);
        checkOutput("ovf_head", con_data, 8'h01);
        con_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h06);
        con_ready = 1'b0;
        readReg(REG_STATUS, d);
        checkOutput("pushpop_full_status", d, 8'h54);
        checkOutput("pushpop_head", con_data, 8'h02);
        con_ready = 1'b1;
        idle(1);
        checkOutput("drain_3", con_data, 8'h03);
        idle(1);
        checkOutput("drain_4", con_data, 8'h04);
        idle(1);
        checkOutput("drain_6", con_data, 8'h06);
        idle(1);
        checkOutput("drain_empty", con_valid, 1'b0);
        con_ready = 1'b0;
`else
        // Console disabled: CON writes vanish, STATUS reports empty
        doReset();
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h48);
        checkOutput("nocon_valid", con_valid, 1'b0);
        checkOutput("nocon_data", con_data, 8'h00);
        readReg(REG_STATUS, d);
        checkOutput("nocon_status", d, 8'h20);
`endif

        // EXIT write in the same cycle as the budget hit wins
        doReset();
        idle(99);
        checkOutput("same_cycle_pre", finish, 1'b0);
        applyStimulus(1'b1, 1'b1, REG_EXIT, 8'h01);
        checkOutput("same_cycle_finish", finish, 1'b1);
        checkOutput("same_cycle_code", exit_code, 8'h01);

        // Reset mid-run clears everything on the next edge
        doReset();
        applyStimulus(1'b1, 1'b1, REG_CON, 8'h41);
        applyStimulus(1'b1, 1'b1, REG_EXIT, 8'h77);
        readReg(REG_STATUS, d);
        checkOutput("midrun_exit", exit_code, 8'h77);
        reset = 1'b1;
        step();
        checkOutput("midrun_rdata", rdata, 8'h00);
        checkOutput("midrun_finish", finish, 1'b0);
        checkOutput("midrun_exit_clr", exit_code, 8'h00);
        checkOutput("midrun_con_valid", con_valid, 1'b0);
        checkOutput("midrun_con_data", con_data, 8'h00);
        reset = 1'b0;
        readReg(REG_STATUS, d);
        checkOutput("midrun_status", d, 8'h20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
